// File: rtl/sprite_pony_pkg.sv
// Shared types and constants for the sprite-core SPI command master.
package sprite_pony_pkg;

  localparam int unsigned SPI_WORD_WIDTH      = 8;
  localparam int unsigned SPI_BIT_CNT_W       = 3;
  localparam logic        SPI_CPOL            = 1'b0;
  localparam logic        SPI_CPHA            = 1'b1;
  localparam int unsigned SPI_HALF_PERIOD_MIN = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LEAD,
    ST_TRAIL,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

endpackage

// File: rtl/spi_cmd_master_tick_gen.sv
// Half-period divider: counts 0..HALF_PERIOD-1 and flags the wrap cycle.
module spi_tick_gen #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick_q is high exactly while cnt_q sits at its last value
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = (cnt_d == CNT_W'(HALF_PERIOD - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/spi_cmd_master.sv
// SPI initiator (CPOL=0, CPHA=1, MSB first) turning a valid/ready byte stream into CS-framed transfers.
module spi_cmd_master
  import sprite_pony_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CS_SETUP    = 1,
  parameter int unsigned CS_HOLD     = 1,
  parameter int unsigned CS_IDLE     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs
);

  localparam int unsigned PH_W = 8;
  localparam int unsigned W    = SPI_WORD_WIDTH;

  spi_state_t         state_q, state_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [W-1:0]       rx_shreg_q, rx_shreg_d;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]    ph_cnt_q, ph_cnt_d;
  logic               last_q, last_d;
  logic               miso_s1_q, miso_s2_q;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rx_valid_q, rx_valid_d;
  logic [W-1:0]       rx_data_q, rx_data_d;
  logic               busy_q, busy_d;
  logic               spi_sclk_q, spi_sclk_d;
  logic               spi_mosi_q, spi_mosi_d;
  logic               spi_cs_q, spi_cs_d;
  logic               tick;
  logic               accept_c;
  logic               state_entry_c;

  assign accept_c      = cmd_valid && cmd_ready_q;
  assign state_entry_c = (state_d != state_q);

  spi_tick_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_entry_c),
    .tick    (tick)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rx_shreg_d = rx_shreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    spi_cs_d   = spi_cs_q;
    spi_mosi_d = spi_mosi_q;
    ph_cnt_d   = tick ? (ph_cnt_q + PH_W'(1)) : ph_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          shreg_d  = cmd_data;
          last_d   = cmd_last;
          spi_cs_d = 1'b0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick && (ph_cnt_q == PH_W'(CS_SETUP - 1))) begin
          bit_cnt_d = SPI_BIT_CNT_W'(W - 1);
          state_d   = ST_LEAD;
        end
      end
      ST_LEAD: begin
        // Sample on the SCLK fall; MOSI/MISO have had the whole high phase to settle
        if (tick) begin
          rx_shreg_d = {rx_shreg_q[W-2:0], miso_s2_q};
          state_d    = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - SPI_BIT_CNT_W'(1);
            shreg_d   = {shreg_q[W-2:0], 1'b0};
            state_d   = ST_LEAD;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shreg_q;
            state_d    = last_q ? ST_HOLD : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (accept_c) begin
          shreg_d   = cmd_data;
          last_d    = cmd_last;
          bit_cnt_d = SPI_BIT_CNT_W'(W - 1);
          state_d   = ST_LEAD;
        end
      end
      ST_HOLD: begin
        if (tick && (ph_cnt_q == PH_W'(CS_HOLD - 1))) begin
          spi_cs_d = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick && (ph_cnt_q == PH_W'(CS_IDLE - 1))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_entry_c) begin
      ph_cnt_d = '0;
    end

    // MOSI launches together with the SCLK rise, from the value being shifted in this cycle
    if ((state_d == ST_LEAD) && (state_q != ST_LEAD)) begin
      spi_mosi_d = shreg_d[W-1];
    end
    if ((state_d == ST_IDLE) || (state_d == ST_GAP)) begin
      spi_mosi_d = 1'b0;
    end

    spi_sclk_d  = (state_d == ST_LEAD) ^ SPI_CPOL;
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      rx_shreg_q  <= '0;
      bit_cnt_q   <= '0;
      ph_cnt_q    <= '0;
      last_q      <= 1'b0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      busy_q      <= 1'b0;
      spi_sclk_q  <= SPI_CPOL;
      spi_mosi_q  <= 1'b0;
      spi_cs_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rx_shreg_q  <= rx_shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ph_cnt_q    <= ph_cnt_d;
      last_q      <= last_d;
      miso_s1_q   <= spi_miso;
      miso_s2_q   <= miso_s1_q;
      cmd_ready_q <= cmd_ready_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      busy_q      <= busy_d;
      spi_sclk_q  <= spi_sclk_d;
      spi_mosi_q  <= spi_mosi_d;
      spi_cs_q    <= spi_cs_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign busy      = busy_q;
  assign spi_sclk  = spi_sclk_q;
  assign spi_mosi  = spi_mosi_q;
  assign spi_cs    = spi_cs_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: loopback DUT at HALF_PERIOD=4 plus a HALF_PERIOD=3 DUT feeding a receiver model.
module tb_spi_cmd_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: HALF_PERIOD=4, MISO looped to MOSI
  logic       cmd_valid = 1'b0, cmd_last = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rx_valid, busy, spi_sclk, spi_mosi, spi_cs;
  logic [7:0] rx_data;

  spi_cmd_master #(.HALF_PERIOD(4), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_last(cmd_last), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_mosi), .spi_cs(spi_cs)
  );

  // DUT 1: minimum divider
  logic       c1_valid = 1'b0, c1_last = 1'b0;
  logic [7:0] c1_data = 8'h00;
  logic       c1_ready, rx1_valid, busy1, sclk1, mosi1, cs1;
  logic [7:0] rx1_data;

  spi_cmd_master #(.HALF_PERIOD(3), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_data(c1_data), .cmd_last(c1_last), .rx_valid(rx1_valid), .rx_data(rx1_data),
    .busy(busy1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(mosi1), .spi_cs(cs1)
  );

  int checks = 0;
  int fails  = 0;
  time accept_t = 0;

  // Bus monitor for DUT 0 (samples on the falling clk edge)
  int         rises0 = 0, cs_low0 = 0, cs_rises0 = 0, rxv0 = 0, nb0 = 0;
  int         cs_high_run0 = 0, last_gap0 = 0;
  logic       sclk_p0 = 1'b0, cs_p0 = 1'b1;
  logic [7:0] mosi_sh0 = 8'h00;
  logic [7:0] mosi_bytes0[$];
  logic [7:0] rx_bytes0[$];
  time        rxv_t0[$];

  always @(negedge clk) begin
    if (spi_sclk && !sclk_p0) begin
      rises0++;
      mosi_sh0 = {mosi_sh0[6:0], spi_mosi};
      nb0++;
      if (nb0 == 8) begin
        mosi_bytes0.push_back(mosi_sh0);
        nb0 = 0;
      end
    end
    if (spi_cs && !cs_p0) begin
      cs_rises0++;
      nb0 = 0;
    end
    if (!spi_cs) begin
      cs_low0++;
      if (cs_p0) last_gap0 = cs_high_run0;
      cs_high_run0 = 0;
    end else begin
      cs_high_run0++;
    end
    if (rx_valid) begin
      rxv0++;
      rx_bytes0.push_back(rx_data);
      rxv_t0.push_back($time);
    end
    sclk_p0 = spi_sclk;
    cs_p0   = spi_cs;
  end

  // Receiver model for DUT 1: CPHA=1 slave samples MOSI on the SCLK fall
  int         falls1 = 0, cs_low1 = 0, nb1 = 0;
  logic       sclk_p1 = 1'b0, cs_p1 = 1'b1;
  logic [7:0] sh1 = 8'h00;
  logic [7:0] mosi_bytes1[$];
  logic [7:0] rx_bytes1[$];

  always @(negedge clk) begin
    if (!sclk1 && sclk_p1) begin
      falls1++;
      sh1 = {sh1[6:0], mosi1};
      nb1++;
      if (nb1 == 8) begin
        mosi_bytes1.push_back(sh1);
        nb1 = 0;
      end
    end
    if (cs1 && !cs_p1) nb1 = 0;
    if (!cs1) cs_low1++;
    if (rx1_valid) rx_bytes1.push_back(rx1_data);
    sclk_p1 = sclk1;
    cs_p1   = cs1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qb(input logic [7:0] q[$], input int i);
    if (i < q.size()) return int'(q[i]);
    return -1;
  endfunction

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", 32'(n < 2000), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_last  = l;
    @(posedge clk);
    accept_t = $time;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!c1_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send1_ready_timeout", 32'(n < 2000), 32'd1);
    c1_valid = 1'b1;
    c1_data  = d;
    c1_last  = l;
    @(posedge clk);
    #1 c1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    @(negedge clk);
    while (!(c1_ready && !busy1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle1_timeout", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int r, c, v, cr, mi, ri, n, viol;
    time ta;

    // Reset values
    #12;
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single byte 0xA5, last=1
    r = rises0; c = cs_low0; v = rxv0; mi = mosi_bytes0.size(); ri = rx_bytes0.size();
    send(8'hA5, 1'b1);
    ta = accept_t;
    wait_idle();
    check("t1_mosi_byte", 32'(qb(mosi_bytes0, mi)), 32'hA5);
    check("t1_sclk_rises", 32'(rises0 - r), 32'd8);
    check("t1_cs_low_clk", 32'(cs_low0 - c), 32'd72);
    check("t1_rx_pulses", 32'(rxv0 - v), 32'd1);
    check("t1_rx_data", 32'(qb(rx_bytes0, ri)), 32'hA5);
    if (rxv_t0.size() > ri) check("t1_latency_clk", 32'((rxv_t0[ri] - ta - 5) / 10), 32'd68);
    else check("t1_latency_missing", 32'(rxv_t0.size()), 32'(ri + 1));

    // 2: back-to-back 0x3C, 0xC3 in one frame
    r = rises0; c = cs_low0; cr = cs_rises0; mi = mosi_bytes0.size(); ri = rx_bytes0.size();
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b1);
    wait_idle();
    check("t2_mosi_b0", 32'(qb(mosi_bytes0, mi)), 32'h3C);
    check("t2_mosi_b1", 32'(qb(mosi_bytes0, mi + 1)), 32'hC3);
    check("t2_sclk_rises", 32'(rises0 - r), 32'd16);
    check("t2_cs_rises", 32'(cs_rises0 - cr), 32'd1);
    check("t2_cs_low_clk", 32'(cs_low0 - c), 32'd137);
    check("t2_rx_b0", 32'(qb(rx_bytes0, ri)), 32'h3C);
    check("t2_rx_b1", 32'(qb(rx_bytes0, ri + 1)), 32'hC3);
    if (rxv_t0.size() > ri + 1) check("t2_rx_spacing_clk", 32'((rxv_t0[ri + 1] - rxv_t0[ri]) / 10), 32'd65);
    else check("t2_rx_spacing_missing", 32'(rxv_t0.size()), 32'(ri + 2));

    // 3: stall in WAIT for 100 clk between bytes
    cr = cs_rises0; mi = mosi_bytes0.size(); ri = rx_bytes0.size();
    send(8'h81, 1'b0);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t3_wait_timeout", 32'(n < 2000), 32'd1);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_sclk !== 1'b0 || spi_cs !== 1'b0 || busy !== 1'b1) viol++;
    end
    check("t3_stall_bus", 32'(viol), 32'd0);
    send(8'h7E, 1'b1);
    wait_idle();
    check("t3_mosi_b0", 32'(qb(mosi_bytes0, mi)), 32'h81);
    check("t3_mosi_b1", 32'(qb(mosi_bytes0, mi + 1)), 32'h7E);
    check("t3_rx_b0", 32'(qb(rx_bytes0, ri)), 32'h81);
    check("t3_rx_b1", 32'(qb(rx_bytes0, ri + 1)), 32'h7E);
    check("t3_cs_rises", 32'(cs_rises0 - cr), 32'd1);

    // 4: asynchronous reset after the 3rd SCLK rise
    r = rises0; v = rxv0; mi = mosi_bytes0.size();
    send(8'hE7, 1'b1);
    n = 0;
    while ((rises0 - r) < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t4_rise_timeout", 32'(n < 2000), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t4_cs", 32'(spi_cs), 32'd1);
    check("t4_sclk", 32'(spi_sclk), 32'd0);
    check("t4_mosi", 32'(spi_mosi), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (150) @(negedge clk);
    check("t4_no_rx_valid", 32'(rxv0 - v), 32'd0);
    check("t4_no_partial_byte", 32'(mosi_bytes0.size() - mi), 32'd0);
    ri = rx_bytes0.size();
    send(8'h96, 1'b1);
    wait_idle();
    check("t4_next_mosi", 32'(qb(mosi_bytes0, mi)), 32'h96);
    check("t4_next_rx", 32'(qb(rx_bytes0, ri)), 32'h96);

    // 5: minimum divider into the receiver model
    c = cs_low1; n = falls1; mi = mosi_bytes1.size(); ri = rx_bytes1.size();
    send1(8'hFF, 1'b1);
    wait_idle1();
    check("t5_recv_ff", 32'(qb(mosi_bytes1, mi)), 32'hFF);
    check("t5_rx_ff", 32'(qb(rx_bytes1, ri)), 32'hFF);
    check("t5_cs_low_clk", 32'(cs_low1 - c), 32'd54);
    check("t5_sclk_falls", 32'(falls1 - n), 32'd8);
    send1(8'h5B, 1'b1);
    wait_idle1();
    check("t5_recv_5b", 32'(qb(mosi_bytes1, mi + 1)), 32'h5B);
    check("t5_rx_5b", 32'(qb(rx_bytes1, ri + 1)), 32'h5B);

    // 6: cmd_valid held through HOLD/GAP
    mi = mosi_bytes0.size(); ri = rx_bytes0.size();
    send(8'h11, 1'b1);
    cmd_valid = 1'b1;
    cmd_data  = 8'h22;
    cmd_last  = 1'b1;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_ready_delay", 32'(n), 32'd80);
    check("t6_ready_only_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle();
    check("t6_mosi_b0", 32'(qb(mosi_bytes0, mi)), 32'h11);
    check("t6_mosi_b1", 32'(qb(mosi_bytes0, mi + 1)), 32'h22);
    check("t6_rx_b0", 32'(qb(rx_bytes0, ri)), 32'h11);
    check("t6_rx_b1", 32'(qb(rx_bytes0, ri + 1)), 32'h22);
    check("t6_cs_gap_clk", 32'(last_gap0), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
